// File: rtl/fc_act_loader_pkg.sv
// fc_pkg: shared state encoding, result-width helper and default settle time for the FC loader.
package fc_pkg;
    typedef enum logic [1:0] {LD_FILL, LD_SETTLE, LD_HOLD} fc_load_state_t;
    localparam int FC_SETTLE = 2;
    function automatic int fc_zw(input int width, input int in);
        return width * 2 + $clog2(in);
    endfunction
endpackage

// File: rtl/fc_act_loader_if.sv
// fc_act_loader_if: activation input stream and registered result stream of the FC loader.
interface fc_act_loader_if
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int ZW    = fc_zw(WIDTH, IN)
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [ZW-1:0]    m_data;
    modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/fc_act_loader_settle_timer.sv
// fc_settle_timer: 4-bit settle counter; start clears it, en advances it, done flags SETTLE-1.
module fc_settle_timer
    import fc_pkg::*;
#(
    parameter int SETTLE = FC_SETTLE
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic done
);
    logic [3:0] scnt;
    always_ff @(posedge clk) begin
        if (rst || start)
            scnt <= '0;
        else if (en)
            scnt <= scnt + 4'd1;
    end
    assign done = scnt == 4'(SETTLE - 1);
endmodule

// File: rtl/fc_act_loader.sv
// fc_act_loader: streams activations into the FC layer input bank, waits for the layer to settle,
// then registers z and offers it downstream. FC_LOADER_OVERLAP_EN lets the next frame load during HOLD.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int SETTLE = FC_SETTLE,
    parameter int ZW     = fc_zw(WIDTH, IN)
) (
    input  logic             clk,
    input  logic             rst,
    fc_act_loader_if.slave   bus,
    output logic [WIDTH-1:0] x [IN],
    input  logic [ZW-1:0]    z,
    output logic             err_len
);
    localparam int CW = $clog2(IN);
    localparam logic [CW-1:0] LAST = CW'(IN - 1);
    localparam logic [1:0] S_FILL   = LD_FILL;
    localparam logic [1:0] S_SETTLE = LD_SETTLE;
    localparam logic [1:0] S_HOLD   = LD_HOLD;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          last_beat;
    logic          hold_rdy;
    logic          done;

`ifdef FC_LOADER_OVERLAP_EN
    // The final beat must wait for FILL so the bank never changes under a pending capture.
    assign hold_rdy = cnt != LAST;
`else
    assign hold_rdy = 1'b0;
`endif

    assign bus.s_ready = !rst && (state == S_FILL || (state == S_HOLD && hold_rdy));
    assign acc         = bus.s_valid && bus.s_ready;
    assign last_beat   = acc && cnt == LAST;

    fc_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (last_beat),
        .en    (state == S_SETTLE),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            cnt         <= '0;
            err_len     <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            for (int i = 0; i < IN; i++)
                x[i] <= '0;
        end else begin
            err_len <= acc && (last_beat ? !bus.s_last : bus.s_last);
            if (acc) begin
                x[cnt] <= bus.s_data;
                cnt    <= (last_beat || bus.s_last) ? '0 : cnt + CW'(1);
            end
            if (last_beat) begin
                state <= S_SETTLE;
            end else if (state == S_SETTLE && done) begin
                state       <= S_HOLD;
                bus.m_valid <= 1'b1;
                bus.m_data  <= z;
            end else if (state == S_HOLD && bus.m_ready) begin
                state       <= S_FILL;
                bus.m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fc_act_loader.md
# fc_act_loader

Sequential front end for the fully-combinational FC neuron layer. It accepts activations one per beat over a valid/ready stream and assembles them into the layer's parallel `x[0:IN-1]` input bank. It holds the bank stable long enough for the layer's multiplier/adder-tree/ReLU path to settle, then registers the layer result `z` and presents it downstream over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 8: activation width; must match the layer's `WIDTH`.
- `IN`, 128: activations per frame; must match the layer's `IN`.
- `SETTLE`, 2: cycles waited after the last write before `z` is sampled; legal range is 1 to 15.
- `ZW`, `WIDTH*2+$clog2(IN)`: result width, equal to the layer's ReLU output width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_valid`  in  1  activation beat valid.
- `s_ready`  out  1  loader accepts a beat.
- `s_data`  in  WIDTH  activation value.
- `s_last`  in  1  marks the final beat of a frame.
- `x`  out  WIDTH × [0:IN-1]  register bank driven into the layer.
- `z`  in  ZW  layer result (combinational from `x`).
- `m_valid`  out  1  registered result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  ZW  registered copy of `z`.
- `err_len`  out  1  one-cycle pulse on a frame-length error.

## Operation
- States are FILL, SETTLE and HOLD; reset enters FILL.
- Beat counter `cnt` has width `$clog2(IN)`. Settle counter `scnt` has 4 bits.

**FILL**
- `s_ready` = 1.
- Each accepted beat (`s_valid && s_ready`) writes `x[cnt] <= s_data` and increments `cnt`.
- Accepted beat with `cnt == IN-1`:
  - Go to SETTLE with `scnt <= 0` and `cnt <= 0`.
  - If `s_last` = 0 on this beat, the frame is still used and `err_len` pulses.
- Accepted beat with `s_last` = 1 and `cnt != IN-1` (early last):
  - The frame is aborted: `cnt <= 0` and the FSM stays in FILL.
  - `err_len` pulses.
  - Already-written `x` entries are kept; no result is produced.

**SETTLE**
- `s_ready` = 0; `scnt` increments each cycle.
- When `scnt == SETTLE-1`: `m_data <= z`, `m_valid <= 1`, go to HOLD.

**HOLD**
- `m_valid` = 1 and `m_data` is stable until `m_ready` = 1.
- On the handshake: `m_valid <= 0` and go to FILL.
- A handshake in the same cycle as entry to HOLD is not possible, because `m_valid` becomes visible one cycle after the capture.

**General**
- `x` is never cleared between frames; entries are only overwritten.
- Arithmetic: `z` is captured as-is with no truncation, and `m_data` is exactly ZW bits.

## Timing
- Reset values: `x[*]` = 0, `m_data` = 0, `m_valid` = 0, `err_len` = 0, `cnt` = 0, state = FILL. `s_ready` is forced to 0 while `rst` = 1.
- Throughput in FILL is one beat per cycle.
- Latency from the last accepted beat (edge N) to `m_valid` = 1 is SETTLE cycles: `m_valid` is high after edge N+SETTLE.
- Minimum frame period is IN + SETTLE + 1 cycles when `m_ready` is held at 1.
- `err_len` is registered: it is high for exactly the cycle after the offending beat.
- `rst` mid-frame or in SETTLE/HOLD: all of the above is restored on the next edge, and any pending result is dropped.
- `s_valid` = 1 while `s_ready` = 0: nothing is written, and the beat must be held by the source.

## Configuration
- Macro: `FC_LOADER_OVERLAP_EN`.
- Defined:
  - In HOLD, `s_ready = (cnt != IN-1)`, so the first IN-1 beats of the next frame load while the result waits. This is safe because `m_data` is registered.
  - An early `s_last` in HOLD aborts the overlapped frame exactly as in FILL.
  - The final beat is accepted only after returning to FILL.
- Not defined: `s_ready` = 0 in HOLD (strictly serial frames).

## Structure
- Shared package `fc_pkg` holds:
  - the `fc_load_state_t` enum (FILL, SETTLE, HOLD);
  - the function `fc_zw(width, in)` returning `width*2+$clog2(in)`;
  - the default `SETTLE` constant.
- One sub-module, `fc_settle_timer`:
  - 4-bit counter with start/clear inputs and a `done` output at SETTLE-1;
  - instantiated once.

## Test plan
- **Nominal frame:** WIDTH=8, IN=128, SETTLE=2, stub layer `z` = sum of `x`. Stream `x[i] = 1` for 128 beats with `s_last` on beat 127 and `m_ready` = 1 → `m_valid` high 2 cycles after the last beat, `m_data` = 128, `err_len` never pulses.
- **Backpressure:** hold `m_ready` = 0 for 10 cycles in HOLD → `m_data` stable and `s_ready` = 0 (macro off). Release → `m_valid` falls the cycle after the handshake and `s_ready` = 1.
- **Early last:** `s_last` on beat 50 → `err_len` pulse, no `m_valid`. A following full 128-beat frame of value 2 → `m_data` = 256.
- **Missing last:** 128 beats with no `s_last` → `err_len` pulses once, and `m_data` is still produced with the correct sum.
- **Reset mid-frame:** assert `rst` after 60 beats → all `x` = 0, `cnt` = 0. A new frame produces the correct result.
- **Overlap (`FC_LOADER_OVERLAP_EN`):** with `m_ready` = 0, stream the next frame → exactly 127 beats are accepted, then `s_ready` = 0. After the handshake, beat 128 is accepted and the next result appears after SETTLE cycles.
